alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter ALU_LAT, default 1, cycles between operand issue and result capture; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0 / req1  input  1  operation request from requester 0 / 1; level, held until done.
REQ-005 a0, b0 / a1, b1  input  4  operands from requester 0 / 1.
REQ-006 sel0 / sel1  input  4  ALU opcode from requester 0 / 1; sel[3]=1 selects signed display.
REQ-007 done0 / done1  output  1  one-cycle pulse; result valid for that requester.
REQ-008 result  output  8  signed ALU result of the most recent completed operation.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 alu_a, alu_b, alu_sel  output  4 each  registered operands/opcode driven to the ALU.
REQ-011 alu_y  input  8  signed ALU output.
REQ-012 disp_val  output  8  value for the 7-segment decoder.
REQ-013 disp_signed  output  1  sel[3] of the operation that produced disp_val.

Function
REQ-014 FSM states: IDLE, BUSY, DONE; no other states reachable.
REQ-015 IDLE: no req high -> stay IDLE; any req high -> BUSY at the same edge.
REQ-016 On the IDLE->BUSY edge, latch winner's a/b/sel into alu_a/alu_b/alu_sel, load wait counter with ALU_LAT, record winner index.
REQ-017 Arbitration: single req wins; both high -> grant the requester not granted last; after reset, requester 0 has priority.
REQ-018 Priority pointer updates only on a grant, never on idle cycles.
REQ-019 BUSY: decrement counter each edge; at the edge where counter==1, capture alu_y into result and disp_val, capture alu_sel[3] into disp_signed, go to DONE.
REQ-020 DONE: assert done of the recorded winner only, for exactly one cycle; next edge -> IDLE.
REQ-021 Latency: req sampled at edge k -> done high in cycle after edge k+ALU_LAT; next grant no earlier than edge k+ALU_LAT+2.
REQ-022 Operands are sampled only at grant; changes to a/b/sel or req of either requester during BUSY/DONE have no effect.
REQ-023 Requester deasserts req by the edge ending its done cycle; req still high in IDLE is treated as a new request.
REQ-024 alu_a/alu_b/alu_sel hold their values after completion until the next grant.
REQ-025 result/disp_val/disp_signed hold until the next capture; no arithmetic or width change (8-bit alu_y copied as-is).
REQ-026 done0 and done1 never high simultaneously; busy low only in IDLE.

Reset
REQ-027 rst_n low asynchronously forces: state IDLE, done0/done1=0, busy=0, result=0, disp_val=0, disp_signed=0, alu_a/alu_b/alu_sel=0, counter=0, pointer=requester 0 priority.
REQ-028 Reset asserted mid-operation aborts it: no done pulse, no capture; operation is not resumed after release.
REQ-029 First grant possible at the first rising edge after rst_n deasserts.

Structure
REQ-030 Shared package alu_pkg holds: state enum (IDLE, BUSY, DONE), OP_W=4, Y_W=8, LAT_W=4.
REQ-031 Arbitration logic sits in sub-module rr_arb2 (2 requests, grant-enable, 1-bit pointer, one-hot grant out).
REQ-032 FSM, counter, operand/result registers live in alu_arbiter top; no combinational path from req/operand inputs to any output.

Verification
REQ-033 Reset then req0=1, a0=0110, b0=1010, sel0=1111, ALU_LAT=1 -> alu_* loaded at edge 1, result=alu_y and done0=1 after edge 2, done1=0.
REQ-034 req0 and req1 high together, held after each done, from reset -> grants alternate 0,1,0,1; four done pulses in that order.
REQ-035 ALU_LAT=4, req1 only -> done1 high exactly 4 cycles after grant edge; busy high for 5 cycles.
REQ-036 Change a0/b0/sel0 during BUSY -> alu_a/alu_b/alu_sel and result reflect grant-time values only.
REQ-037 rst_n low during BUSY -> all outputs 0 immediately, no done pulse; after release req1 and req0 both high -> requester 0 granted first.
REQ-038 sel0=0111 then sel1=1111 completions -> disp_signed 0 then 1, disp_val equals each captured alu_y.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and widths for the ALU arbiter block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

  localparam int OP_W  = 4;  // operand / opcode width
  localparam int Y_W   = 8;  // ALU result width
  localparam int LAT_W = 4;  // wait counter width, covers ALU_LAT 1..15

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of requester, ALU and display signals for alu_arbiter.
// Latency: n/a (wires only).
// Backpressure: requests are levels held until the matching done pulse.
// Ports: req0/1, a0/1, b0/1, sel0/1 (requesters), done0/1, result, busy,
//        alu_a/b/sel (to ALU), alu_y (from ALU), disp_val, disp_signed.
interface alu_arbiter_if;
  import alu_pkg::*;

  logic            req0, req1;
  logic [OP_W-1:0] a0, b0, sel0;
  logic [OP_W-1:0] a1, b1, sel1;
  logic            done0, done1;
  logic [Y_W-1:0]  result;
  logic            busy;
  logic [OP_W-1:0] alu_a, alu_b, alu_sel;
  logic [Y_W-1:0]  alu_y;
  logic [Y_W-1:0]  disp_val;
  logic            disp_signed;

  // Arbiter side
  modport slave (
    input  req0, req1, a0, b0, sel0, a1, b1, sel1, alu_y,
    output done0, done1, result, busy, alu_a, alu_b, alu_sel,
           disp_val, disp_signed
  );

  // Requester / ALU side
  modport master (
    output req0, req1, a0, b0, sel0, a1, b1, sel1, alu_y,
    input  done0, done1, result, busy, alu_a, alu_b, alu_sel,
           disp_val, disp_signed
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a one-bit priority pointer.
// Latency: combinational grant; pointer updates on the granting edge.
// Backpressure: no grant while en_i is low; pointer frozen on idle cycles.
// Ports: clk, rst_n, req_i[1:0], en_i, gnt_o[1:0] (one-hot or zero).
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  // ptr_q = index of the requester that wins a tie
  logic ptr_q, ptr_d;
  logic [1:0] gnt;

  always_comb begin
    gnt   = 2'b00;
    ptr_d = ptr_q;
    if (en_i) begin
      if (req_i == 2'b11) begin
        gnt = ptr_q ? 2'b10 : 2'b01;
      end else begin
        gnt = req_i;
      end
    end
    // Whoever was just served loses the next tie
    if (gnt != 2'b00) begin
      ptr_d = gnt[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign gnt_o = gnt;

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters; captures result for display.
// Latency: grant edge -> ALU_LAT edges -> one-cycle done; next grant 2 edges later.
// Backpressure: requests wait in IDLE; inputs ignored while BUSY/DONE.
// Ports: clk, rst_n, bus (alu_arbiter_if.slave). ALU_LAT legal range 1..15.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int ALU_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_arbiter_if.slave        bus
);

  localparam logic [LAT_W-1:0] CNT_ONE  = LAT_W'(1);
  localparam logic [LAT_W-1:0] CNT_LOAD = LAT_W'(ALU_LAT);

  state_t          state_q, state_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;
  logic            win_q, win_d;
  logic [OP_W-1:0] alu_a_q, alu_a_d;
  logic [OP_W-1:0] alu_b_q, alu_b_d;
  logic [OP_W-1:0] alu_sel_q, alu_sel_d;
  logic [Y_W-1:0]  res_q, res_d;
  logic            sgn_q, sgn_d;

  logic [1:0]      gnt;
  logic            gnt_en;
  logic            any_gnt;

  // Arbitration only happens in IDLE, so the pointer never moves elsewhere
  assign gnt_en  = (state_q == IDLE);
  assign any_gnt = |gnt;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i ({bus.req1, bus.req0}),
    .en_i  (gnt_en),
    .gnt_o (gnt)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    win_d     = win_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_sel_d = alu_sel_q;
    res_d     = res_q;
    sgn_d     = sgn_q;
    case (state_q)
      IDLE: begin
        if (any_gnt) begin
          state_d   = BUSY;
          cnt_d     = CNT_LOAD;
          win_d     = gnt[1];
          alu_a_d   = gnt[1] ? bus.a1   : bus.a0;
          alu_b_d   = gnt[1] ? bus.b1   : bus.b0;
          alu_sel_d = gnt[1] ? bus.sel1 : bus.sel0;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = DONE;
          res_d   = bus.alu_y;
          sgn_d   = alu_sel_q[3];
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      win_q     <= 1'b0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_sel_q <= '0;
      res_q     <= '0;
      sgn_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      win_q     <= win_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_sel_q <= alu_sel_d;
      res_q     <= res_d;
      sgn_q     <= sgn_d;
    end
  end

  // All outputs come straight from registers
  assign bus.done0       = (state_q == DONE) && !win_q;
  assign bus.done1       = (state_q == DONE) &&  win_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.result      = res_q;
  assign bus.disp_val    = res_q;
  assign bus.disp_signed = sgn_q;
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_sel     = alu_sel_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one DUT with ALU_LAT=1, one with ALU_LAT=4.
// The ALU stand-in computes y = {alu_a, alu_b} + alu_sel (8-bit wrap).
module tb_alu_arbiter;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  alu_arbiter_if bus1();
  alu_arbiter_if bus4();

  alu_arbiter #(.ALU_LAT(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  alu_arbiter #(.ALU_LAT(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  assign bus1.alu_y = {bus1.alu_a, bus1.alu_b} + {4'h0, bus1.alu_sel};
  assign bus4.alu_y = {bus4.alu_a, bus4.alu_b} + {4'h0, bus4.alu_sel};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    bus1.req0 = 0; bus1.req1 = 0; bus1.a0 = 0; bus1.b0 = 0; bus1.sel0 = 0;
    bus1.a1 = 0; bus1.b1 = 0; bus1.sel1 = 0;
    bus4.req0 = 0; bus4.req1 = 0; bus4.a0 = 0; bus4.b0 = 0; bus4.sel0 = 0;
    bus4.a1 = 0; bus4.b1 = 0; bus4.sel1 = 0;
  endtask

  // Releases reset at a falling edge so the next rising edge can grant
  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    tests++; if (bus1.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus1.busy); end
    tests++; if (bus1.done0 !== 1'b0 || bus1.done1 !== 1'b0) begin fails++; $display("FAIL reset_done got %b%b want 00", bus1.done1, bus1.done0); end
    tests++; if (bus1.result !== 8'h00) begin fails++; $display("FAIL reset_result got %h want 00", bus1.result); end
    tests++; if (bus1.disp_val !== 8'h00 || bus1.disp_signed !== 1'b0) begin fails++; $display("FAIL reset_disp got %h/%b want 00/0", bus1.disp_val, bus1.disp_signed); end
    tests++; if ({bus1.alu_a, bus1.alu_b, bus1.alu_sel} !== 12'h000) begin fails++; $display("FAIL reset_alu got %h want 000", {bus1.alu_a, bus1.alu_b, bus1.alu_sel}); end
    tests++; if (bus4.busy !== 1'b0) begin fails++; $display("FAIL reset_busy4 got %b want 0", bus4.busy); end
    rst_n = 1'b1;
  endtask

  // Called right after reset release: grant on the very first edge
  task automatic test_basic();
    bus1.req0 = 1; bus1.a0 = 4'b0110; bus1.b0 = 4'b1010; bus1.sel0 = 4'b1111;
    @(negedge clk);
    tests++; if ({bus1.alu_a, bus1.alu_b, bus1.alu_sel} !== 12'h6AF) begin fails++; $display("FAIL basic_alu got %h want 6af", {bus1.alu_a, bus1.alu_b, bus1.alu_sel}); end
    tests++; if (bus1.busy !== 1'b1 || bus1.done0 !== 1'b0) begin fails++; $display("FAIL basic_busy got busy=%b done0=%b want 1/0", bus1.busy, bus1.done0); end
    @(negedge clk);
    tests++; if (bus1.done0 !== 1'b1 || bus1.done1 !== 1'b0) begin fails++; $display("FAIL basic_done got %b%b want 01", bus1.done1, bus1.done0); end
    tests++; if (bus1.result !== 8'h79 || bus1.disp_val !== 8'h79) begin fails++; $display("FAIL basic_result got %h/%h want 79", bus1.result, bus1.disp_val); end
    tests++; if (bus1.disp_signed !== 1'b1) begin fails++; $display("FAIL basic_signed got %b want 1", bus1.disp_signed); end
    bus1.req0 = 0;
    @(negedge clk);
    tests++; if (bus1.busy !== 1'b0 || bus1.done0 !== 1'b0) begin fails++; $display("FAIL basic_idle got busy=%b done0=%b want 0/0", bus1.busy, bus1.done0); end
  endtask

  task automatic test_alternate();
    int order[4];
    int n;
    n = 0;
    do_reset();
    bus1.req0 = 1; bus1.a0 = 4'h1; bus1.b0 = 4'h1;
    bus1.req1 = 1; bus1.a1 = 4'h2; bus1.b1 = 4'h2;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge clk);
      if (bus1.done0 === 1'b1 && bus1.done1 === 1'b1) begin
        tests++; fails++; $display("FAIL alt_both_done at cycle %0d got 11 want one-hot", c);
      end
      if (bus1.done0 === 1'b1) begin order[n] = 0; n++; end
      else if (bus1.done1 === 1'b1) begin order[n] = 1; n++; end
    end
    bus1.req0 = 0; bus1.req1 = 0;
    tests++; if (n != 4) begin fails++; $display("FAIL alt_count got %0d want 4", n); end
    for (int i = 0; i < n; i++) begin
      tests++; if (order[i] != (i % 2)) begin fails++; $display("FAIL alt_order[%0d] got %0d want %0d", i, order[i], i % 2); end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_latency4();
    int busy_cnt;
    int done_at;
    busy_cnt = 0; done_at = 0;
    do_reset();
    bus4.req1 = 1; bus4.a1 = 4'h3; bus4.b1 = 4'h4; bus4.sel1 = 4'h8;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      if (bus4.busy === 1'b1) busy_cnt++;
      if (bus4.done1 === 1'b1) begin
        if (done_at == 0) done_at = i;
        bus4.req1 = 0;
      end
    end
    tests++; if (done_at != 5) begin fails++; $display("FAIL lat4_done got cycle %0d want 5", done_at); end
    tests++; if (busy_cnt != 5) begin fails++; $display("FAIL lat4_busy got %0d cycles want 5", busy_cnt); end
    tests++; if (bus4.result !== 8'h3C || bus4.disp_signed !== 1'b1) begin fails++; $display("FAIL lat4_result got %h/%b want 3c/1", bus4.result, bus4.disp_signed); end
  endtask

  task automatic test_operand_hold();
    bit got;
    got = 0;
    do_reset();
    bus4.req0 = 1; bus4.a0 = 4'h5; bus4.b0 = 4'h2; bus4.sel0 = 4'h1;
    @(negedge clk);
    bus4.a0 = 4'hF; bus4.b0 = 4'hF; bus4.sel0 = 4'hF;
    @(negedge clk);
    tests++; if ({bus4.alu_a, bus4.alu_b, bus4.alu_sel} !== 12'h521) begin fails++; $display("FAIL hold_alu got %h want 521", {bus4.alu_a, bus4.alu_b, bus4.alu_sel}); end
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (bus4.done0 === 1'b1) got = 1;
    end
    tests++; if (!got) begin fails++; $display("FAIL hold_done got no pulse want done0"); end
    tests++; if (bus4.result !== 8'h53 || bus4.disp_signed !== 1'b0) begin fails++; $display("FAIL hold_result got %h/%b want 53/0", bus4.result, bus4.disp_signed); end
    bus4.req0 = 0;
    repeat (2) @(negedge clk);
    tests++; if ({bus4.alu_a, bus4.alu_b, bus4.alu_sel} !== 12'h521 || bus4.busy !== 1'b0) begin fails++; $display("FAIL hold_after got %h busy=%b want 521 busy=0", {bus4.alu_a, bus4.alu_b, bus4.alu_sel}, bus4.busy); end
    tests++; if (bus4.result !== 8'h53) begin fails++; $display("FAIL hold_result_after got %h want 53", bus4.result); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus1.req0 = 1; bus1.a0 = 4'h7; bus1.b0 = 4'h1; bus1.sel0 = 4'h2;
    @(negedge clk);
    tests++; if (bus1.busy !== 1'b1) begin fails++; $display("FAIL rmid_busy got %b want 1", bus1.busy); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (bus1.busy !== 1'b0 || bus1.done0 !== 1'b0 || {bus1.alu_a, bus1.alu_b, bus1.alu_sel} !== 12'h000) begin fails++; $display("FAIL rmid_async got busy=%b done0=%b alu=%h want 0/0/000", bus1.busy, bus1.done0, {bus1.alu_a, bus1.alu_b, bus1.alu_sel}); end
    bus1.req1 = 1; bus1.a1 = 4'h9; bus1.b1 = 4'h9; bus1.sel1 = 4'h9;
    @(negedge clk);
    tests++; if (bus1.done0 !== 1'b0 || bus1.result !== 8'h00) begin fails++; $display("FAIL rmid_nodone got done0=%b result=%h want 0/00", bus1.done0, bus1.result); end
    rst_n = 1'b1;
    @(negedge clk);
    tests++; if (bus1.alu_a !== 4'h7 || bus1.busy !== 1'b1) begin fails++; $display("FAIL rmid_grant got alu_a=%h busy=%b want 7/1", bus1.alu_a, bus1.busy); end
    @(negedge clk);
    tests++; if (bus1.done0 !== 1'b1 || bus1.done1 !== 1'b0 || bus1.result !== 8'h73) begin fails++; $display("FAIL rmid_done got %b%b result=%h want 01/73", bus1.done1, bus1.done0, bus1.result); end
    bus1.req0 = 0; bus1.req1 = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_disp();
    bit got;
    do_reset();
    got = 0;
    bus1.req0 = 1; bus1.a0 = 4'h1; bus1.b0 = 4'h2; bus1.sel0 = 4'b0111;
    for (int c = 0; c < 8 && !got; c++) begin
      @(negedge clk);
      if (bus1.done0 === 1'b1) got = 1;
    end
    tests++; if (!got) begin fails++; $display("FAIL disp0_done got no pulse want done0"); end
    tests++; if (bus1.disp_val !== 8'h19 || bus1.disp_signed !== 1'b0) begin fails++; $display("FAIL disp0 got %h/%b want 19/0", bus1.disp_val, bus1.disp_signed); end
    bus1.req0 = 0;
    @(negedge clk);
    tests++; if (bus1.disp_val !== 8'h19) begin fails++; $display("FAIL disp0_hold got %h want 19", bus1.disp_val); end
    got = 0;
    bus1.req1 = 1; bus1.a1 = 4'h8; bus1.b1 = 4'h0; bus1.sel1 = 4'b1111;
    for (int c = 0; c < 8 && !got; c++) begin
      @(negedge clk);
      if (bus1.done1 === 1'b1) got = 1;
    end
    tests++; if (!got) begin fails++; $display("FAIL disp1_done got no pulse want done1"); end
    tests++; if (bus1.disp_val !== 8'h8F || bus1.disp_signed !== 1'b1 || bus1.result !== 8'h8F) begin fails++; $display("FAIL disp1 got %h/%b/%h want 8f/1/8f", bus1.disp_val, bus1.disp_signed, bus1.result); end
    bus1.req1 = 0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_basic();
    test_alternate();
    test_latency4();
    test_operand_hold();
    test_reset_mid();
    test_disp();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before the bench completed");
    $fatal(1, "watchdog");
  end

endmodule
